// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory bus and instruction hand-off bundle for the fetch stage
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [7:0]        imem_rdata;
  logic [7:0]        instr;
  logic [3:0]        opcode;
  logic              instr_valid;
  logic              instr_ready;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  // memory and decode side
  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder, single-outstanding instruction fetch and valid/ready hand-off
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  instr_fetch_unit_if.master       bus,
  input  logic                     jmp_en,
  input  logic                     je_en,
  input  logic                     flag,
  input  logic [ADDR_W-1:0]        jmp_target,
  output logic [ADDR_W-1:0]        pc,
  output logic [CNT_W-1:0]         retired_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_done;
  logic              handshake;
  logic              taken;

  // ack only counts while our request is actually on the bus
  assign fetch_done = (state_q == FETCH) && bus.imem_ack;
  assign handshake  = (state_q == HOLD) && bus.instr_ready;
  assign taken      = jmp_en | (je_en & flag);

  // state and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: idle once after reset, then alternate fetch/hold
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (fetch_done) state_d = HOLD;
      HOLD:    if (handshake) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // next datapath values: capture on ack, redirect and retire on hand-off
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (fetch_done) begin
      instr_d = bus.imem_rdata;
    end
    if (handshake) begin
      pc_d  = taken ? jmp_target : pc_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // outputs decode straight from the registered state
  always_comb begin
    bus.imem_req    = (state_q == FETCH);
    bus.imem_addr   = pc_q;
    bus.instr       = instr_q;
    bus.opcode      = instr_q[7:4];
    bus.instr_valid = (state_q == HOLD);
    pc              = pc_q;
    retired_count   = cnt_q;
  end

endmodule
